// File: rtl/dem_tree_sequencer.sv
// Time-multiplexes one SwitchingBlock across every node of a binary DEM tree,
// walking nodes in heap order and publishing the leaf vector as unit-element enables.
`timescale 1ns/1ps
module dem_tree_sequencer #(
    parameter int          LEVELS    = 3,
    parameter int          WIDTH     = 4,
    parameter int          SW_LAT    = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     x_in_i,
    output logic                 sw_valid_o,
    output logic [WIDTH-1:0]     sw_x_o,
    output logic [WIDTH-1:0]     sw_q_o,
    output logic                 sw_pn_o,
    input  logic [WIDTH-1:0]     sw_x1_i,
    input  logic [WIDTH-1:0]     sw_x2_i,
    output logic [2**LEVELS-1:0] elem_o,
    output logic                 out_valid_o,
    output logic [1:0]           err_o
);

    localparam int NLEAF = 2**LEVELS;
    localparam int NINT  = NLEAF - 1;
    localparam int NNODE = 2 * NLEAF - 1;
    localparam int KW    = $clog2(NNODE);
    localparam logic [WIDTH-1:0] MAXV     = WIDTH'(NLEAF);
    localparam logic [WIDTH-1:0] ONEV     = WIDTH'(1);
    localparam logic [KW-1:0]    LAST_K   = KW'(NINT - 1);
    localparam logic [1:0]       LAT_LAST = (SW_LAT > 0) ? 2'(SW_LAT - 1) : 2'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right with feedback into bit 15
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    state_t              r_state, w_state_nxt;
    logic [KW-1:0]       r_k, w_k_nxt;
    logic [1:0]          r_lat, w_lat_nxt;
    logic [WIDTH-1:0]    r_node [NNODE];
    logic [WIDTH-1:0]    w_node_nxt [NNODE];
    logic [15:0]         r_lfsr, w_lfsr_nxt;
    logic                r_in_ready;
    logic                r_sw_valid;
    logic [WIDTH-1:0]    r_sw_x, w_sw_x_nxt;
    logic [WIDTH-1:0]    r_sw_q, w_sw_q_nxt;
    logic                r_sw_pn, w_sw_pn_nxt;
    logic [NLEAF-1:0]    r_elem, w_elem_nxt;
    logic                r_out_valid, w_out_valid_nxt;
    logic [1:0]          r_err, w_err_nxt;
    logic                w_capture;
    logic [KW-1:0]       w_c1, w_c2;
    logic [WIDTH:0]      w_sum;

    assign w_c1  = {r_k[KW-2:0], 1'b0} + KW'(1);
    assign w_c2  = {r_k[KW-2:0], 1'b0} + KW'(2);
    assign w_sum = {1'b0, sw_x1_i} + {1'b0, sw_x2_i};

    // Next-state, node-capture and output-update logic
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_lat_nxt       = r_lat;
        w_node_nxt      = r_node;
        w_lfsr_nxt      = r_lfsr;
        w_sw_q_nxt      = r_sw_q;
        w_elem_nxt      = r_elem;
        w_out_valid_nxt = 1'b0;
        w_err_nxt       = r_err;
        w_capture       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid_i && r_in_ready) begin
                    w_node_nxt[0] = (x_in_i > MAXV) ? MAXV : x_in_i;
                    w_sw_q_nxt    = (x_in_i > MAXV) ? MAXV : x_in_i;
                    w_err_nxt[1]  = r_err[1] | (x_in_i > MAXV);
                    w_k_nxt       = {KW{1'b0}};
                    w_state_nxt   = ISSUE;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            ISSUE: begin
                w_lfsr_nxt = lfsr_step(r_lfsr);
                w_lat_nxt  = 2'd0;
                if (SW_LAT == 0) begin
                    w_capture = 1'b1;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_capture = 1'b1;
                end else begin
                    w_lat_nxt = r_lat + 2'd1;
                end
            end
            DONE: begin
                // A leaf above one still drives its element but flags the split fault
                for (int j = 0; j < NLEAF; j++) begin
                    w_elem_nxt[j] = (r_node[NINT + j] != {WIDTH{1'b0}});
                    if (r_node[NINT + j] > ONEV) begin
                        w_err_nxt[0] = 1'b1;
                    end else begin
                        w_err_nxt[0] = w_err_nxt[0];
                    end
                end
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_capture) begin
            w_node_nxt[w_c1] = sw_x1_i;
            w_node_nxt[w_c2] = sw_x2_i;
            if (w_sum != {1'b0, r_node[r_k]}) begin
                w_err_nxt[0] = 1'b1;
            end else begin
                w_err_nxt[0] = w_err_nxt[0];
            end
            if (r_k == LAST_K) begin
                w_state_nxt = DONE;
            end else begin
                w_k_nxt     = r_k + KW'(1);
                w_state_nxt = ISSUE;
            end
        end else begin
            w_k_nxt = w_k_nxt;
        end

        // Node value and PN bit are latched on entry to ISSUE and held through WAIT
        w_sw_x_nxt  = (w_state_nxt == ISSUE) ? w_node_nxt[w_k_nxt] : r_sw_x;
        w_sw_pn_nxt = (w_state_nxt == ISSUE) ? w_lfsr_nxt[0]       : r_sw_pn;
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_k         <= {KW{1'b0}};
            r_lat       <= 2'd0;
            for (int i = 0; i < NNODE; i++) begin
                r_node[i] <= {WIDTH{1'b0}};
            end
            r_lfsr      <= LFSR_SEED;
            r_in_ready  <= 1'b1;
            r_sw_valid  <= 1'b0;
            r_sw_x      <= {WIDTH{1'b0}};
            r_sw_q      <= {WIDTH{1'b0}};
            r_sw_pn     <= LFSR_SEED[0];
            r_elem      <= {NLEAF{1'b0}};
            r_out_valid <= 1'b0;
            r_err       <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_lat       <= w_lat_nxt;
            r_node      <= w_node_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_in_ready  <= (w_state_nxt == IDLE);
            r_sw_valid  <= (w_state_nxt == ISSUE);
            r_sw_x      <= w_sw_x_nxt;
            r_sw_q      <= w_sw_q_nxt;
            r_sw_pn     <= w_sw_pn_nxt;
            r_elem      <= w_elem_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign sw_valid_o  = r_sw_valid;
    assign sw_x_o      = r_sw_x;
    assign sw_q_o      = r_sw_q;
    assign sw_pn_o     = r_sw_pn;
    assign elem_o      = r_elem;
    assign out_valid_o = r_out_valid;
    assign err_o       = r_err;

endmodule

// File: tb/tb_dem_tree_sequencer.sv
// Scoreboard bench for dem_tree_sequencer: directed codes with an ideal (optionally
// faulty) SwitchingBlock model; a negedge monitor checks each published leaf vector.
`timescale 1ns/1ps
module tb_dem_tree_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [3:0] x_in_i = 4'd0;
    logic       sw_valid_o;
    logic [3:0] sw_x_o, sw_q_o;
    logic       sw_pn_o;
    logic [3:0] sw_x1_i, sw_x2_i;
    logic [7:0] elem_o;
    logic       out_valid_o;
    logic [1:0] err_o;

    always #5 clk_i = ~clk_i;

    dem_tree_sequencer #(.LEVELS(3), .WIDTH(4), .SW_LAT(1), .LFSR_SEED(SEED)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .x_in_i(x_in_i), .sw_valid_o(sw_valid_o), .sw_x_o(sw_x_o), .sw_q_o(sw_q_o),
        .sw_pn_o(sw_pn_o), .sw_x1_i(sw_x1_i), .sw_x2_i(sw_x2_i), .elem_o(elem_o),
        .out_valid_o(out_valid_o), .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] elem;
        logic       chk_elem;
        int         pop;
        logic       chk_pop;
        logic [1:0] err;
    } exp_t;
    exp_t sb[$];

    function automatic exp_t mk(input logic [7:0] elem, input logic chk_elem,
                                input int pop, input logic chk_pop, input logic [1:0] err);
        exp_t e;
        e.elem = elem; e.chk_elem = chk_elem; e.pop = pop; e.chk_pop = chk_pop; e.err = err;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Ideal switching block: ceil/floor split steered by the PN bit, optional +1 fault on node 1
    logic       corrupt_en = 1'b0;
    logic [2:0] m_issue_cnt = 3'd0;
    logic [2:0] m_cur = 3'd0;
    logic [4:0] m_t;
    always @(posedge clk_i) begin
        if (reset_i) begin
            m_issue_cnt <= 3'd0;
            m_cur       <= 3'd0;
        end else if (sw_valid_o) begin
            m_cur       <= m_issue_cnt;
            m_issue_cnt <= (m_issue_cnt == 3'd6) ? 3'd0 : m_issue_cnt + 3'd1;
        end
    end
    always_comb begin
        m_t     = {1'b0, sw_x_o} + {4'd0, sw_pn_o};
        sw_x1_i = m_t[4:1] + ((corrupt_en && m_cur == 3'd1) ? 4'd1 : 4'd0);
        sw_x2_i = sw_x_o - m_t[4:1];
    end

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Monitor: PN sequence, issue count, latency and scoreboard comparison
    int          cyc = 0;
    int          acc_edge = 0;
    int          pulses = 0;
    logic [15:0] ref_lfsr = SEED;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) begin
        exp_t e;
        if (sw_valid_o) check("sw_pn", int'(sw_pn_o), int'(ref_lfsr[0]));
        if (out_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("latency", cyc - acc_edge, 15);
                check("sw_valid_pulses", pulses, 7);
                if (e.chk_elem) check("elem", int'(elem_o), int'(e.elem));
                if (e.chk_pop)  check("popcount", $countones(elem_o), e.pop);
                check("err", int'(err_o), int'(e.err));
            end
        end
        if (reset_i) begin
            ref_lfsr <= SEED;
            pulses   <= 0;
            sb.delete();
        end else begin
            if (sw_valid_o) ref_lfsr <= ref_step(ref_lfsr);
            pulses <= out_valid_o ? int'(sw_valid_o) : pulses + int'(sw_valid_o);
            if (in_valid_i && in_ready_o) acc_edge <= cyc + 1;
        end
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (in_ready_o) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 1, 0);
    endtask

    task automatic send(input logic [3:0] code, input exp_t e);
        logic [3:0] c;
        c = (code > 4'd8) ? 4'd8 : code;
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; x_in_i = code;
        sb.push_back(e);
        wait_ready();
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        check("sw_q", int'(sw_q_o), int'(c));
        check("root_sw_x", int'(sw_x_o), int'(c));
        check("root_sw_valid", int'(sw_valid_o), 1);
    endtask

    task automatic wait_out();
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (out_valid_o) begin ok = 1'b1; break; end
        end
        if (!ok) check("out_valid_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1; reset_i = 1'b1;
        @(posedge clk_i); #1; reset_i = 1'b0;
    endtask

    initial begin
        logic [15:0] seed_v;
        int low, t0, t1, outs;
        seed_v = SEED;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_in_ready", int'(in_ready_o), 1);
        check("rst_sw_valid", int'(sw_valid_o), 0);
        check("rst_sw_x", int'(sw_x_o), 0);
        check("rst_sw_q", int'(sw_q_o), 0);
        check("rst_sw_pn", int'(sw_pn_o), int'(seed_v[0]));
        check("rst_elem", int'(elem_o), 0);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_err", int'(err_o), 0);

        send(4'd0, mk(8'h00, 1'b1, 0, 1'b1, 2'b00)); wait_out();
        send(4'd8, mk(8'hFF, 1'b1, 8, 1'b1, 2'b00)); wait_out();

        // Back-to-back 5 then 3 with valid held high throughout
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; x_in_i = 4'd5;
        sb.push_back(mk(8'h00, 1'b0, 5, 1'b1, 2'b00));
        wait_ready();
        t0 = cyc;
        @(posedge clk_i); #1;
        x_in_i = 4'd3;
        sb.push_back(mk(8'h00, 1'b0, 3, 1'b1, 2'b00));
        low = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (in_ready_o) break;
            low++;
        end
        t1 = cyc;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        check("ready_low_cycles", low, 15);
        check("accept_spacing", t1 - t0, 16);
        check("btb_sw_q", int'(sw_q_o), 3);
        wait_out();

        send(4'd12, mk(8'hFF, 1'b1, 8, 1'b1, 2'b10)); wait_out();
        do_reset();
        @(negedge clk_i);
        check("err_after_reset", int'(err_o), 0);

        // Faulty split on node 1, then a clean sample: the error stays sticky
        corrupt_en = 1'b1;
        send(4'd5, mk(8'h00, 1'b0, 0, 1'b0, 2'b01)); wait_out();
        corrupt_en = 1'b0;
        send(4'd3, mk(8'h00, 1'b0, 3, 1'b1, 2'b01)); wait_out();
        check("err_sticky", int'(err_o), 1);
        do_reset();
        @(negedge clk_i);
        check("err_cleared", int'(err_o), 0);

        // Abort a sample mid-walk
        send(4'd8, mk(8'hFF, 1'b1, 8, 1'b1, 2'b00)); wait_out();
        send(4'd5, mk(8'h00, 1'b0, 5, 1'b1, 2'b00));
        repeat (4) @(posedge clk_i);
        #1 reset_i = 1'b1;
        @(posedge clk_i); #1 reset_i = 1'b0;
        @(negedge clk_i);
        check("abort_elem", int'(elem_o), 0);
        check("abort_in_ready", int'(in_ready_o), 1);
        check("abort_err", int'(err_o), 0);
        check("abort_sw_pn", int'(sw_pn_o), int'(seed_v[0]));
        outs = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk_i);
            if (out_valid_o) outs++;
        end
        check("abort_no_out_valid", outs, 0);

        send(4'd0, mk(8'h00, 1'b1, 0, 1'b1, 2'b00));
        check("first_pn_after_reset", int'(sw_pn_o), int'(seed_v[0]));
        wait_out();

        repeat (3) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
